// File: rtl/fir_out_requant.sv
// Output requantiser for the cascaded-DSP FIR: rounds the wide accumulator to the sample width,
// saturates it and queues it in a first-word-fallthrough FIFO with saturation/overflow statistics.
module fir_out_requant #(
    parameter int DIN_W  = 54,
    parameter int DOUT_W = 18,
    parameter int SHIFT  = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overflow,
    output logic [15:0]       sat_cnt,
    input  logic              clr_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam int HI = SHIFT + DOUT_W - 1;
    localparam logic [DIN_W:0]  ROUND_C = {{DIN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [DOUT_W-1:0] POS_SAT = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] NEG_SAT = {1'b1, {(DOUT_W-1){1'b0}}};
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic              s1_valid_q, s1_valid_d;
    logic [DIN_W:0]    s1_sum_q, s1_sum_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_sat_q, s2_sat_d;
    logic [DOUT_W-1:0] s2_data_q, s2_data_d;

    logic [DOUT_W-1:0] mem_q [DEPTH];
    logic [DOUT_W-1:0] mem_d [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       sat_cnt_q, sat_cnt_d;

    logic [DIN_W-HI:0] s1_top;
    logic              in_range;
    logic [AW:0]       count;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic              unused_low_bits;

    // Stage 1: sign-extend one bit so the rounding constant can never wrap
    always_comb begin
        s1_valid_d = din_valid;
        s1_sum_d   = s1_sum_q;
        if (din_valid) begin
            s1_sum_d = {din[DIN_W-1], din} + ROUND_C;
        end
    end

    // The shifted value fits the output only if every bit from the output MSB upward is a copy of the sign
    assign s1_top          = s1_sum_q[DIN_W:HI];
    assign in_range        = (s1_top == '0) || (s1_top == '1);
    assign unused_low_bits = ^s1_sum_q[SHIFT-1:0];

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            s2_sat_d = !in_range;
            if (in_range) begin
                s2_data_d = s1_sum_q[HI:SHIFT];
            end else if (s1_sum_q[DIN_W]) begin
                s2_data_d = NEG_SAT;
            end else begin
                s2_data_d = POS_SAT;
            end
        end
    end

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == DEPTH_C);
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign push       = s2_valid_q && (!full || pop);
    assign drop       = s2_valid_q && full && !pop;
    assign dout       = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = s2_data_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Saturations are counted as they leave stage 2, independent of whether the FIFO accepts them
    always_comb begin
        overflow_d = overflow_q | drop;
        sat_cnt_d  = sat_cnt_q;
        if (s2_valid_q && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
        if (clr_stats) begin
            overflow_d = 1'b0;
            sat_cnt_d  = '0;
        end
    end

    assign overflow = overflow_q;
    assign sat_cnt  = sat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_data_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_sat_q   <= s2_sat_d;
            s2_data_q  <= s2_data_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: directed scenarios plus random traffic against a
// queue-based reference model of the rounding, saturation and FIFO behaviour.
module tb_fir_out_requant;

    localparam int DIN_W  = 54;
    localparam int DOUT_W = 18;
    localparam int SHIFT  = 8;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIN_W-1:0]  din;
    logic              din_valid;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              overflow;
    logic [15:0]       sat_cnt;
    logic              clr_stats;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: two pipeline slots, a FIFO queue and the statistics
    logic [DOUT_W-1:0] mq[$];
    bit                p1_v, p2_v, p1_s, p2_s;
    logic [DOUT_W-1:0] p1_d, p2_d;
    bit                m_ovf;
    int                m_sat;

    fir_out_requant #(
        .DIN_W (DIN_W),
        .DOUT_W(DOUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overflow  (overflow),
        .sat_cnt   (sat_cnt),
        .clr_stats (clr_stats)
    );

    always #5 clk = ~clk;

    function automatic logic [DIN_W-1:0] to_din(input longint x);
        return x[DIN_W-1:0];
    endfunction

    // Round-half-up division by 2^SHIFT followed by clamping; returns {saturated, sample}
    function automatic logic [DOUT_W:0] requant(input logic [DIN_W-1:0] d);
        longint v, n, q;
        longint div;
        longint maxv, minv;
        div  = longint'(1) << SHIFT;
        maxv = (longint'(1) << (DOUT_W - 1)) - 1;
        minv = -(longint'(1) << (DOUT_W - 1));
        v = $signed(d);
        n = v + div / 2;
        if (n >= 0) q = n / div;
        else        q = -((-n + div - 1) / div);
        if (q > maxv) return {1'b1, 18'h1FFFF};
        if (q < minv) return {1'b1, 18'h20000};
        return {1'b0, q[DOUT_W-1:0]};
    endfunction

    task automatic model_reset();
        mq.delete();
        p1_v  = 0;
        p2_v  = 0;
        p1_s  = 0;
        p2_s  = 0;
        p1_d  = '0;
        p2_d  = '0;
        m_ovf = 0;
        m_sat = 0;
    endtask

    task automatic model_edge(input bit v, input logic [DIN_W-1:0] d, input bit rdy, input bit clr);
        logic [DOUT_W:0] r;
        bit do_pop;
        bit was_full;
        do_pop   = (mq.size() != 0) && rdy;
        was_full = (mq.size() == DEPTH);
        if (do_pop) void'(mq.pop_front());
        if (p2_v) begin
            if (!was_full || do_pop) mq.push_back(p2_d);
            else m_ovf = 1;
            if (p2_s && m_sat < 65535) m_sat++;
        end
        if (clr) begin
            m_ovf = 0;
            m_sat = 0;
        end
        p2_v = p1_v;
        p2_s = p1_s;
        p2_d = p1_d;
        r    = requant(d);
        p1_v = v;
        p1_s = r[DOUT_W];
        p1_d = r[DOUT_W-1:0];
    endtask

    // Called at a falling edge: drive inputs, advance the model, move to the next falling edge
    task automatic step(input bit v, input logic [DIN_W-1:0] d, input bit rdy, input bit clr);
        din_valid  = v;
        din        = d;
        dout_ready = rdy;
        clr_stats  = clr;
        model_edge(v, d, rdy, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dout_valid got %b want 0", dout_valid); end
        n_tests++;
        if (dout !== '0) begin n_fail++; $display("[TB] FAIL reset_dout got %h want 0", dout); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
        n_tests++;
        if (sat_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_sat_cnt got %0d want 0", sat_cnt); end
    endtask

    task automatic test_rounding();
        longint vals[4] = '{768, 384, -384, -385};
        longint exps[4] = '{3, 2, -1, -2};
        logic [DOUT_W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            e = exps[i][DOUT_W-1:0];
            step(1'b1, to_din(vals[i]), 1'b1, 1'b0);
            n_tests++;
            if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL round_early1[%0d] valid got %b want 0", i, dout_valid); end
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL round_early2[%0d] valid got %b want 0", i, dout_valid); end
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (dout_valid !== 1'b1 || dout !== e) begin
                n_fail++;
                $display("[TB] FAIL round_out[%0d] got valid=%b dout=%h want valid=1 dout=%h", i, dout_valid, dout, e);
            end
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL round_pop[%0d] valid got %b want 0", i, dout_valid); end
        end
        n_tests++;
        if (sat_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL round_sat_cnt got %0d want 0", sat_cnt); end
    endtask

    task automatic test_saturation();
        longint vals[3];
        logic [DOUT_W-1:0] exps[3] = '{18'h1FFFF, 18'h20000, 18'h1FFFF};
        vals[0] = longint'(1) << 30;
        vals[1] = -(longint'(1) << 30);
        vals[2] = (longint'(1) << 53) - 1;
        for (int i = 0; i < 3; i++) step(1'b1, to_din(vals[i]), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (sat_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL sat_cnt got %0d want 3", sat_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dout_valid !== 1'b1 || dout !== exps[i]) begin
                n_fail++;
                $display("[TB] FAIL sat_out[%0d] got valid=%b dout=%h want valid=1 dout=%h", i, dout_valid, dout, exps[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_drain valid got %b want 0", dout_valid); end
        step(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (sat_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL sat_clear got %0d want 0", sat_cnt); end
    endtask

    task automatic test_overflow();
        logic [DOUT_W-1:0] e;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, to_din(longint'(k) * 256), 1'b0, 1'b0);
            n_tests++;
            if (overflow !== m_ovf) begin n_fail++; $display("[TB] FAIL ovf_fill[%0d] got %b want %b", k, overflow, m_ovf); end
        end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_before_drop got %b want 0", overflow); end
        step(1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_after_drop got %b want 1", overflow); end
        step(1'b0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            e = DOUT_W'(k);
            n_tests++;
            if (dout_valid !== 1'b1 || dout !== e) begin
                n_fail++;
                $display("[TB] FAIL ovf_read[%0d] got valid=%b dout=%h want valid=1 dout=%h", k, dout_valid, dout, e);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_empty valid got %b want 0", dout_valid); end
        step(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear got %b want 0", overflow); end
    endtask

    // FIFO is full with a sample waiting in stage 2 when ready rises, forcing push and pop together
    task automatic test_back_to_back();
        int next_k = 1;
        bit rdy;
        for (int i = 1; i <= 42; i++) begin
            rdy = (i > 10);
            if (dout_valid && rdy) begin
                n_tests++;
                if (dout !== DOUT_W'(next_k)) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_order got %h want %h", dout, DOUT_W'(next_k));
                end
                next_k++;
            end
            if (i <= 30) step(1'b1, to_din(longint'(i) * 256), rdy, 1'b0);
            else         step(1'b0, '0, rdy, 1'b0);
            n_tests++;
            if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_overflow[%0d] got %b want 0", i, overflow); end
        end
        n_tests++;
        if (next_k != 31) begin n_fail++; $display("[TB] FAIL b2b_count got %0d want 30", next_k - 1); end
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_empty valid got %b want 0", dout_valid); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) step(1'b1, to_din(longint'(1) << 40), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (dout_valid !== 1'b1 || sat_cnt !== 16'd5) begin
            n_fail++;
            $display("[TB] FAIL mid_preload got valid=%b sat_cnt=%0d want valid=1 sat_cnt=5", dout_valid, sat_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dout_valid !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_rst_fifo got valid=%b dout=%h want valid=0 dout=0", dout_valid, dout);
        end
        n_tests++;
        if (overflow !== 1'b0 || sat_cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_rst_stats got overflow=%b sat_cnt=%0d want 0 0", overflow, sat_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, to_din(768), 1'b1, 1'b0);
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_lat1 valid got %b want 0", dout_valid); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_lat2 valid got %b want 0", dout_valid); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== 18'd3) begin
            n_fail++;
            $display("[TB] FAIL mid_out got valid=%b dout=%h want valid=1 dout=3", dout_valid, dout);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        longint x, base, off;
        bit v, rdy;
        base = longint'(1) << 25;
        for (int i = 0; i < 515; i++) begin
            case ($urandom_range(0, 3))
                0: x = longint'({$urandom(), $urandom()});
                1: x = longint'($urandom_range(0, 1 << 27)) - (longint'(1) << 26);
                2: begin
                    off = longint'($urandom_range(0, 2048)) - 1024;
                    x = ($urandom_range(0, 1) == 1) ? base + off : -base + off;
                end
                default: x = (longint'($urandom_range(0, 200)) - 100) * 256 + (($urandom_range(0, 1) == 1) ? 128 : 127);
            endcase
            v   = (i < 500) && ($urandom_range(0, 1) == 1);
            rdy = (i >= 500) || ($urandom_range(0, 3) != 0);
            step(v, to_din(x), rdy, 1'b0);
            n_tests++;
            if (dout_valid !== (mq.size() != 0)) begin
                n_fail++;
                $display("[TB] FAIL rnd_valid[%0d] got %b want %b", i, dout_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_tests++;
                if (dout !== mq[0]) begin n_fail++; $display("[TB] FAIL rnd_dout[%0d] got %h want %h", i, dout, mq[0]); end
            end
            n_tests++;
            if (overflow !== m_ovf || sat_cnt !== 16'(m_sat)) begin
                n_fail++;
                $display("[TB] FAIL rnd_stats[%0d] got ovf=%b sat=%0d want ovf=%b sat=%0d", i, overflow, sat_cnt, m_ovf, m_sat);
            end
        end
        n_tests++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_drain valid got %b want 0", dout_valid); end
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        clr_stats  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_rounding();
        test_saturation();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        step(1'b0, '0, 1'b0, 1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
